// File: rtl/player.sv
// ============================================================================
// Module   : player
// Purpose  : Replays bytes 0..limit-1 from the capture RAM to a byte sink,
//            one valid strobe per byte, with optional idle gap between bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module player #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int GAP        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] limit,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  playing,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] C_GAP_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_limit;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [7:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_read;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_playing;
  logic                  r_done;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_index_next;

  // The sink's busy is honoured in the same cycle, so the strobe is decoded
  // directly from the SEND state rather than registered a cycle late.
  assign w_accept     = (r_state == S_SEND) && !busy;
  assign w_index_next = r_index + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_limit   <= '0;
      r_index   <= '0;
      r_count   <= '0;
      r_addr    <= '0;
      r_read    <= 1'b0;
      r_data    <= '0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_read <= 1'b0;
      r_done <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_playing <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              if (limit != '0) begin
                r_limit   <= limit;
                r_index   <= '0;
                r_addr    <= '0;
                r_read    <= 1'b1;
                r_playing <= 1'b1;
                r_state   <= S_FETCH;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
          S_FETCH: r_state <= S_WAIT;
          S_WAIT: begin
            r_data  <= mem_data;
            r_state <= S_SEND;
          end
          S_SEND: begin
            if (!busy) begin
              r_index <= w_index_next;
              if (w_index_next == r_limit) begin
                r_done    <= 1'b1;
                r_playing <= 1'b0;
                r_state   <= S_DONE;
              end else if (GAP > 0) begin
                r_count <= '0;
                r_state <= S_GAP;
              end else begin
                r_addr  <= w_index_next;
                r_read  <= 1'b1;
                r_state <= S_FETCH;
              end
            end
          end
          S_GAP: begin
            if (r_count == C_GAP_LAST) begin
              r_addr  <= r_index;
              r_read  <= 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_count <= r_count + 8'd1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign addr     = r_addr;
  assign read     = r_read;
  assign data_out = r_data;
  assign valid    = w_accept;
  assign playing  = r_playing;
  assign done     = r_done;

endmodule

`default_nettype wire
